// File: rtl/pipelined_cla_adder_pkg.sv
// ---------------------------------------------------------------------------
// pipelined_cla_adder_pkg
// Shared types and helpers for the pipelined carry-lookahead adder.
//   gp_t        : generate/propagate pair for a bit, group or whole word
//   GP_IDENTITY : neutral element of gp_combine (g=0, p=1)
//   gp_combine  : merges a more-significant span (hi) with a less-significant
//                 span (lo) into the g/p of the concatenated span
//   chunk_of    : bits resolved per pipeline stage
//   cfg_ok      : parameter legality check used at elaboration
// ---------------------------------------------------------------------------
package pipelined_cla_adder_pkg;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  localparam gp_t GP_IDENTITY = '{g: 1'b0, p: 1'b1};

  function automatic gp_t gp_combine(gp_t hi, gp_t lo);
    gp_t r;
    r.g = hi.g | (hi.p & lo.g);
    r.p = hi.p & lo.p;
    return r;
  endfunction

  function automatic int chunk_of(int width, int stages);
    return width / stages;
  endfunction

  function automatic bit cfg_ok(int width, int stages, int group);
    return (stages > 0) && (group > 0) && (width % stages == 0) &&
           ((width / stages) % group == 0);
  endfunction

endpackage

// File: rtl/pipelined_cla_adder_if.sv
// ---------------------------------------------------------------------------
// pipelined_cla_adder_if
// Operand/result bus of the pipelined adder.
//   in_valid/in_ready    : operand handshake (a, b, cin [, sub])
//   out_valid/out_ready  : result handshake (sum, cout, ovf, blk_g, blk_p)
// modport master : the producer/consumer around the adder
// modport slave  : the adder itself
// Macro PIPELINED_CLA_ADDER_SUB_EN adds the 'sub' operand bit.
// ---------------------------------------------------------------------------
interface pipelined_cla_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef PIPELINED_CLA_ADDER_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             blk_g;
  logic             blk_p;

  modport master (
`ifdef PIPELINED_CLA_ADDER_SUB_EN
    output sub,
`endif
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, blk_g, blk_p
  );

  modport slave (
`ifdef PIPELINED_CLA_ADDER_SUB_EN
    input  sub,
`endif
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf, blk_g, blk_p
  );

endinterface

// File: rtl/pipelined_cla_adder_cla_group.sv
// ---------------------------------------------------------------------------
// cla_group
// Combinational GROUP-bit carry-lookahead cell. Every internal carry is
// formed from the prefix g/p of the bits below it and cin, so no carry
// ripples bit to bit inside the group.
//   a, b : GROUP-bit operand slices
//   cin  : carry into the group's LSB
//   sum  : GROUP-bit sum
//   cout : carry out of the group's MSB
//   g, p : group generate / propagate (independent of cin)
// ---------------------------------------------------------------------------
module cla_group
  import pipelined_cla_adder_pkg::*;
#(
  parameter int GROUP = 4
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             cin,
  output logic [GROUP-1:0] sum,
  output logic             cout,
  output logic             g,
  output logic             p
);

  gp_t            acc;
  logic [GROUP:0] c;

  // NOTE: every variable gets a value before the loop so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    acc  = GP_IDENTITY;
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < GROUP; i++) begin
      sum[i] = a[i] ^ b[i] ^ c[i];
      acc    = gp_combine(gp_t'{g: a[i] & b[i], p: a[i] ^ b[i]}, acc);
      c[i+1] = acc.g | (acc.p & cin);
    end
  end

  assign cout = c[GROUP];
  assign g    = acc.g;
  assign p    = acc.p;

endmodule

// File: rtl/pipelined_cla_adder.sv
// ---------------------------------------------------------------------------
// pipelined_cla_adder
// WIDTH-bit adder split into STAGES slices of CHUNK = WIDTH/STAGES bits.
// Stage k adds slice k with CHUNK/GROUP lookahead groups (group carries
// ripple inside the slice) and registers the partial sum, slice carry,
// running overflow candidate and running word g/p. Operands travel forward
// so the next stage can pick up its slice. Latency is STAGES cycles from
// acceptance to out_valid; the whole pipe stalls together when the result
// is not taken.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : pipelined_cla_adder_if.slave (operand / result handshake)
// Macro PIPELINED_CLA_ADDER_SUB_EN: adds bus.sub; when set, stage 0 uses ~b
// with carry-in 1 so the result is a-b (cout=1 means no borrow).
// ---------------------------------------------------------------------------
module pipelined_cla_adder
  import pipelined_cla_adder_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4,
  parameter int GROUP  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pipelined_cla_adder_if.slave  bus
);

  localparam int CHUNK = chunk_of(WIDTH, STAGES);
  localparam int NGRP  = CHUNK / GROUP;
  localparam int LAST  = STAGES - 1;

  if (!cfg_ok(WIDTH, STAGES, GROUP)) begin : g_bad_cfg
    $error("pipelined_cla_adder: WIDTH must split into STAGES slices of whole GROUPs");
  end

  // Stage registers, index k = output of stage k.
  logic             v_q   [STAGES];
  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic [WIDTH-1:0] s_q   [STAGES];
  logic             c_q   [STAGES];
  logic             ovf_q [STAGES];
  gp_t              gp_q  [STAGES];

  logic             nxt_v   [STAGES];
  logic [WIDTH-1:0] nxt_a   [STAGES];
  logic [WIDTH-1:0] nxt_b   [STAGES];
  logic [WIDTH-1:0] nxt_s   [STAGES];
  logic             nxt_c   [STAGES];
  logic             nxt_ovf [STAGES];
  gp_t              nxt_gp  [STAGES];

  logic             adv;
  logic [WIDTH-1:0] b_in;
  logic             c_in;

  // The pipe only moves as a whole: a held result blocks every stage.
  assign adv          = !v_q[LAST] || bus.out_ready;
  assign bus.in_ready = adv;

`ifdef PIPELINED_CLA_ADDER_SUB_EN
  assign b_in = bus.sub ? ~bus.b : bus.b;
  assign c_in = bus.sub ? 1'b1   : bus.cin;
`else
  assign b_in = bus.b;
  assign c_in = bus.cin;
`endif

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] src_a, src_b, src_s, new_s;
    logic             src_c, src_v;
    gp_t              src_gp, sl_gp;
    logic [CHUNK-1:0] sl_a, sl_b, sl_s;
    logic [NGRP-1:0]  grp_g, grp_p;
    logic             sl_cout;

    if (k == 0) begin : g_src_in
      assign src_a  = bus.a;
      assign src_b  = b_in;
      assign src_c  = c_in;
      assign src_s  = '0;
      assign src_gp = GP_IDENTITY;
      assign src_v  = bus.in_valid;
    end else begin : g_src_reg
      assign src_a  = a_q[k-1];
      assign src_b  = b_q[k-1];
      assign src_c  = c_q[k-1];
      assign src_s  = s_q[k-1];
      assign src_gp = gp_q[k-1];
      assign src_v  = v_q[k-1];
    end

    assign sl_a = src_a[k*CHUNK +: CHUNK];
    assign sl_b = src_b[k*CHUNK +: CHUNK];

    for (genvar j = 0; j < NGRP; j++) begin : g_grp
      logic gcin, gcout;
      if (j == 0) begin : g_c_first
        assign gcin = src_c;
      end else begin : g_c_chain
        assign gcin = g_grp[j-1].gcout;
      end
      cla_group #(.GROUP(GROUP)) u_grp (
        .a    (sl_a[j*GROUP +: GROUP]),
        .b    (sl_b[j*GROUP +: GROUP]),
        .cin  (gcin),
        .sum  (sl_s[j*GROUP +: GROUP]),
        .cout (gcout),
        .g    (grp_g[j]),
        .p    (grp_p[j])
      );
    end

    assign sl_cout = g_grp[NGRP-1].gcout;

    always_comb begin
      sl_gp = GP_IDENTITY;
      for (int j = 0; j < NGRP; j++) begin
        sl_gp = gp_combine(gp_t'{g: grp_g[j], p: grp_p[j]}, sl_gp);
      end
    end

    always_comb begin
      new_s = src_s;
      new_s[k*CHUNK +: CHUNK] = sl_s;
    end

    assign nxt_v[k]   = src_v;
    assign nxt_a[k]   = src_a;
    assign nxt_b[k]   = src_b;
    assign nxt_s[k]   = new_s;
    assign nxt_c[k]   = sl_cout;
    // Carry into the slice MSB is recovered as a^b^sum at that bit; only
    // the last stage's candidate reaches ovf.
    assign nxt_ovf[k] = (sl_a[CHUNK-1] ^ sl_b[CHUNK-1] ^ sl_s[CHUNK-1]) ^ sl_cout;
    assign nxt_gp[k]  = gp_combine(sl_gp, src_gp);
  end

  // NOTE: state updates use non-blocking assignments so every stage loads
  // the value its predecessor held before this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: data registers are cleared as well as the valid bits so the
      // result outputs read 0 during and right after reset.
      for (int k = 0; k < STAGES; k++) begin
        v_q[k]   <= 1'b0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        s_q[k]   <= '0;
        c_q[k]   <= 1'b0;
        ovf_q[k] <= 1'b0;
        gp_q[k]  <= '0;
      end
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k]   <= nxt_v[k];
        a_q[k]   <= nxt_a[k];
        b_q[k]   <= nxt_b[k];
        s_q[k]   <= nxt_s[k];
        c_q[k]   <= nxt_c[k];
        ovf_q[k] <= nxt_ovf[k];
        gp_q[k]  <= nxt_gp[k];
      end
    end
  end

  assign bus.out_valid = v_q[LAST];
  assign bus.sum       = s_q[LAST];
  assign bus.cout      = c_q[LAST];
  assign bus.ovf       = ovf_q[LAST];
  assign bus.blk_g     = gp_q[LAST].g;
  assign bus.blk_p     = gp_q[LAST].p;

endmodule

// File: doc/pipelined_cla_adder.md
Name: pipelined_cla_adder

Overview:
- Parametrised, pipelined carry-lookahead adder that generalises the single-bit generate/propagate full-adder cell to WIDTH bits.
- The operand is split into STAGES equal slices. Each slice is resolved in one pipeline stage by 4-bit-style lookahead groups, and the carry is registered between stages.
- Valid/ready handshake on input and output with global stall. Sits on the datapath wherever a wide add must close timing at high clock rates.

Parameters:
- WIDTH, 32, operand/sum width in bits; must be a multiple of STAGES.
- STAGES, 4, pipeline depth = latency in cycles; each stage resolves CHUNK = WIDTH/STAGES bits.
- GROUP, 4, lookahead group size inside a slice; CHUNK must be a multiple of GROUP.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands present
- in_ready  out  1  block accepts operands this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry into bit 0
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts result
- sum  out  WIDTH  A+B+cin mod 2^WIDTH
- cout  out  1  carry out of bit WIDTH-1
- ovf  out  1  signed overflow (carry into MSB XOR carry out of MSB)
- blk_g  out  1  block generate of full word (all bits), registered with result
- blk_p  out  1  block propagate of full word, registered with result

Behaviour:
- Reset (rst_n low, asynchronous): all stage valid bits clear; out_valid=0; sum, cout, ovf, blk_g, blk_p = 0. Data registers also clear to 0. Release is synchronous to the next clk edge.
- Advance rule: adv = !out_valid || out_ready.
  - in_ready = adv, and is combinational from out_ready.
  - When adv=1, every stage register loads from its predecessor.
  - When adv=0, the whole pipe holds. There is no bubble collapse.
- Stage 0 captures a, b, cin, and in_valid (as v0) when adv=1. An input is accepted only when in_valid && in_ready.
- Stage k (0..STAGES-1) processing:
  - Computes bits [k*CHUNK +: CHUNK].
  - Per-bit g=a&b, p=a^b.
  - Group G/P and lookahead carries within each GROUP. Groups inside a slice ripple their group carries.
  - Slice carry-out, running ovf candidate, and running word-level G/P are registered with the partial sum.
  - Unprocessed upper operand bits and already-computed lower sum bits travel forward in registers.
- Word-level P = AND of all bit p. Word-level G = carry out with cin forced 0.
- Latency: a result accepted at edge N appears with out_valid=1 after edge N+STAGES-1 (registered output of the last stage). Throughput is 1 result/cycle when out_ready=1.
- The result holds stable while out_valid=1 && out_ready=0.
- Bubbles: if in_valid=0 when adv=1, an invalid slot enters the pipe. Its data is don't-care, but it must not assert out_valid.
- STAGES=1: a single registered stage; behaviour is otherwise identical.
- Reset mid-operation: all in-flight results are discarded and none emerges after reset release.

Optional Feature:
- Macro: PIPELINED_CLA_ADDER_SUB_EN.
- Defined:
  - Adds port sub (in, 1) sampled with a and b.
  - When sub=1, stage 0 stores ~b and uses carry-in = 1 (cin is ignored). The result is a-b, cout=1 means no borrow, and ovf is signed subtraction overflow.
- Undefined: the sub port is absent and the block is add-only, exactly as above.

Decomposition:
- Package pipelined_cla_adder_pkg:
  - typedef gp_t struct {g, p}.
  - Function gp_combine(hi, lo) returning {hi.g | hi.p&lo.g, hi.p&lo.p}.
  - Localparam helper for CHUNK = WIDTH/STAGES and an elaboration check that WIDTH%STAGES==0 and CHUNK%GROUP==0.
- Sub-module cla_group (parameter GROUP): combinational.
  - Inputs: a, b, cin.
  - Outputs: sum, cout, group g, group p.
  - Instantiated CHUNK/GROUP times per stage by generate.

Test Plan:
- WIDTH=16, STAGES=4, GROUP=4, out_ready=1: a=0xFFFF, b=0x0001, cin=0 → after 4 cycles out_valid=1, sum=0x0000, cout=1, ovf=0, blk_p=0, blk_g=1.
- Signed overflow: a=0x7FFF, b=0x0001 → sum=0x8000, cout=0, ovf=1. Then a=0x5555, b=0xAAAA, cin=1 → sum=0x0000, cout=1, blk_p=1, blk_g=0.
- Back-to-back streaming: 100 random pairs with in_valid held high and out_ready=1 → 100 consecutive out_valid cycles, results in order and matching the reference model; in_ready never drops.
- Backpressure: out_ready=0 for 3 cycles while a result is valid → sum/out_valid held, in_ready=0, no input lost or duplicated; out_ready=1 resumes in order.
- Reset mid-operation: 3 transactions in flight, pulse rst_n low asynchronously between edges → outputs 0 immediately; after release, no stale out_valid within 10 cycles.
- With PIPELINED_CLA_ADDER_SUB_EN defined: sub=1, a=0x0005, b=0x0007 → sum=0xFFFE, cout=0. Then a=0x8000, b=0x0001 → sum=0x7FFF, ovf=1.
